bias_activate: RTL and testbench
================================

Name: bias_activate

Overview:
- Per-neuron output stage directly downstream of the multiply-accumulate array.
- Takes SIZE_B independent accumulated sums (valid/ready per lane), adds a per-neuron signed bias, applies the activation, and saturates each result back to WIDTH bits for the next layer.
- The bias vector is loaded through its own handshake. A small FSM guarantees that no sum is ever combined with a half-updated bias set.

Parameters:
- SIZE_A, 32, fan-in of the upstream accumulator; sets input width IW = $clog2(SIZE_A)+WIDTH.
- SIZE_B, 32, number of neurons (lanes).
- WIDTH, 4, bias and output width, signed two's complement.
- BURST, "yes", "yes" = 2-entry skid per lane, full throughput; "no" = 1-entry register per lane, at most one transfer every 2 cycles.

Ports:
- iCLK  input  1  clock
- iRST  input  1  reset
- iValid_AM_B  input  1  bias vector valid
- oReady_AM_B  output  1  bias vector ready
- iData_AM_B  input  SIZE_B*WIDTH  bias vector, lane i at [i*WIDTH+:WIDTH]
- iValid_AM_WS  input  SIZE_B  per-lane sum valid
- oReady_AM_WS  output  SIZE_B  per-lane sum ready
- iData_AM_WS  input  SIZE_B*IW  per-lane signed sums
- oValid_BM  output  SIZE_B  per-lane result valid
- iReady_BM  input  SIZE_B  per-lane result ready
- oData_BM  output  SIZE_B*WIDTH  per-lane activated results

Behaviour:
- Clocking and reset:
  - One clock, iCLK.
  - iRST is synchronous and active-low.
  - While iRST=0 at a rising edge: FSM goes to LOAD, all lane buffers are emptied, the bias register is cleared to 0, and oValid_BM=0, oReady_AM_WS=0, oReady_AM_B=1 after the edge.
  - Reset asserted mid-operation discards all buffered data without producing output.
- Handshakes:
  - Transfer occurs when valid&ready are high at a rising edge.
  - A valid, once raised, is held with stable data until accepted.
  - Every ready output is driven from registers only, with no combinational path from the same-side valid.
- FSM:
  - LOAD: oReady_AM_B=1 and oReady_AM_WS=0. A bias transfer latches all SIZE_B biases and moves the FSM to RUN.
  - RUN: oReady_AM_B=0. Lanes accept sums per the buffer rules. If iValid_AM_B=1, go to DRAIN; lanes do not accept in that same cycle's registered-ready update.
  - DRAIN: oReady_AM_WS=0. When all lane buffers are empty, oReady_AM_B=1. A bias transfer returns the FSM to RUN with the new biases. Data accepted before DRAIN always uses the old bias.
- Arithmetic (registered at lane entry, latency 1 cycle from input transfer to oValid_BM):
  - s = sext(sum, IW+1) + sext(bias_i, IW+1).
  - s then goes through the activation (see Optional Feature).
  - The result is saturated to signed WIDTH: above 2^(WIDTH-1)-1 clamps to max, below -2^(WIDTH-1) clamps to min.
- Lane buffer, BURST="yes":
  - Main plus skid entry.
  - oReady_AM_WS[i] = skid empty.
  - Simultaneous input and output transfer keeps occupancy unchanged.
  - Output order is FIFO.
- Lane buffer, BURST="no":
  - Single entry; oReady_AM_WS[i] = entry empty.
  - Occupancy is never both filled and drained in one edge.
- Lanes are fully independent: a stall on one lane never blocks another.

Optional Feature:
- Macro: BIAS_ACTIVATE_RELU_EN.
- Defined: ReLU is applied before saturation (s<0 → 0), so outputs lie in 0..2^(WIDTH-1)-1.
- Undefined: linear activation; s is signed-saturated only.

Test Plan:
All scenarios use SIZE_A=4, WIDTH=4 (IW=6), SIZE_B=2, BURST="yes".
- Reset then data with no bias: oReady_AM_WS stays 0 and oValid_BM=0 until a bias transfer; after the bias transfer, oReady_AM_WS=2'b11 one cycle later.
- Bias {1,2}, lane0 sum 5 → oData lane0=3'd... (5+1)=6 one cycle after transfer; lane1 sum 20 → 22 saturates to 7.
- Lane0 sum -10 with bias 3: with macro → 0; without macro → -7 (4'b1001). Lane1 sum -20 with bias -8, without macro → -8 (4'b1000).
- Back-to-back burst on lane0 with iReady_BM[0]=0 for 3 cycles: exactly 2 words accepted, then oReady_AM_WS[0]=0; on release, outputs appear in order with no loss or duplicate; lane1 is unaffected.
- Bias reload in RUN with lane0 buffer holding 2 words: FSM enters DRAIN, inputs are blocked, and oReady_AM_B rises only after both words leave. The held words use the old bias; the next sum uses the new bias.
- iRST=0 for one cycle while both lanes are full: all valids low after the edge, FSM in LOAD, bias register 0, no stale output after a new bias load.

Source files
------------

// File: rtl/bias_activate.sv
`default_nettype none
// ============================================================================
// Module   : bias_activate
// Purpose  : Per-lane bias add, activation and signed saturation, with a
//            LOAD/RUN/DRAIN FSM that keeps bias updates atomic w.r.t. sums.
//            Optional ReLU activation: define BIAS_ACTIVATE_RELU_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bias_activate #(
    parameter int    SIZE_A = 32,
    parameter int    SIZE_B = 32,
    parameter int    WIDTH  = 4,
    parameter string BURST  = "yes"
) (
    input  logic                                       iCLK,
    input  logic                                       iRST,
    input  logic                                       iValid_AM_B,
    output logic                                       oReady_AM_B,
    input  logic [SIZE_B*WIDTH-1:0]                    iData_AM_B,
    input  logic [SIZE_B-1:0]                          iValid_AM_WS,
    output logic [SIZE_B-1:0]                          oReady_AM_WS,
    input  logic [SIZE_B*($clog2(SIZE_A)+WIDTH)-1:0]   iData_AM_WS,
    output logic [SIZE_B-1:0]                          oValid_BM,
    input  logic [SIZE_B-1:0]                          iReady_BM,
    output logic [SIZE_B*WIDTH-1:0]                    oData_BM
);

    localparam int c_IW = $clog2(SIZE_A) + WIDTH;

    localparam int                   c_maxInt = 2**(WIDTH-1) - 1;
    localparam int                   c_minInt = -(2**(WIDTH-1));
    localparam logic signed [c_IW:0] c_satMax = c_maxInt[c_IW:0];
    localparam logic signed [c_IW:0] c_satMin = c_minInt[c_IW:0];

    localparam logic [1:0] c_stLoad  = 2'd0;
    localparam logic [1:0] c_stRun   = 2'd1;
    localparam logic [1:0] c_stDrain = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_stateNext;
    logic [SIZE_B*WIDTH-1:0] r_bias;
    logic [SIZE_B-1:0]       w_laneOcc;
    logic                    w_allEmpty;
    logic                    w_biasReady;
    logic                    w_laneEnable;
    logic                    w_biasXfer;

    function automatic logic [WIDTH-1:0] activate(input logic signed [c_IW:0] s);
        logic signed [c_IW:0] a;
        a = s;
`ifdef BIAS_ACTIVATE_RELU_EN
        if (s[c_IW]) a = '0;
`endif
        if (a > c_satMax)
            return c_satMax[WIDTH-1:0];
        else if (a < c_satMin)
            return c_satMin[WIDTH-1:0];
        else
            return a[WIDTH-1:0];
    endfunction

    assign w_allEmpty = ~|w_laneOcc;
    assign w_biasXfer = iValid_AM_B & w_biasReady;
    assign oReady_AM_B = w_biasReady;

    // State register
    always_ff @(posedge iCLK) begin
        if (!iRST) r_state <= c_stLoad;
        else       r_state <= w_stateNext;
    end

    // Next-state logic
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_stLoad:  if (w_biasXfer)  w_stateNext = c_stRun;
            c_stRun:   if (iValid_AM_B) w_stateNext = c_stDrain;
            c_stDrain: if (w_biasXfer)  w_stateNext = c_stRun;
            default:                    w_stateNext = c_stLoad;
        endcase
    end

    // Outputs depend only on registered state and lane occupancy
    always_comb begin
        w_biasReady  = 1'b0;
        w_laneEnable = 1'b0;
        case (r_state)
            c_stLoad:  w_biasReady  = 1'b1;
            c_stRun:   w_laneEnable = 1'b1;
            c_stDrain: w_biasReady  = w_allEmpty;
            default:   w_biasReady  = 1'b0;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST)           r_bias <= '0;
        else if (w_biasXfer) r_bias <= iData_AM_B;
    end

    for (genvar i = 0; i < SIZE_B; i++) begin : g_lane
        logic signed [c_IW-1:0] w_sum;
        logic        [WIDTH-1:0] w_bias;
        logic signed [c_IW:0]   w_s;
        logic        [WIDTH-1:0] w_result;
        logic                    w_inXfer;
        logic                    w_outXfer;

        assign w_sum    = iData_AM_WS[i*c_IW +: c_IW];
        assign w_bias   = r_bias[i*WIDTH +: WIDTH];
        assign w_s      = {w_sum[c_IW-1], w_sum}
                        + {{(c_IW+1-WIDTH){w_bias[WIDTH-1]}}, w_bias};
        assign w_result = activate(w_s);

        if (BURST == "yes") begin : g_skid
            logic             r_mainValid;
            logic             r_skidValid;
            logic [WIDTH-1:0] r_mainData;
            logic [WIDTH-1:0] r_skidData;

            assign oReady_AM_WS[i]           = w_laneEnable & ~r_skidValid;
            assign w_inXfer                  = iValid_AM_WS[i] & oReady_AM_WS[i];
            assign w_outXfer                 = r_mainValid & iReady_BM[i];
            assign oValid_BM[i]              = r_mainValid;
            assign oData_BM[i*WIDTH +: WIDTH] = r_mainData;
            assign w_laneOcc[i]              = r_mainValid;

            // Skid only fills while main is stalled; main empty implies skid empty
            always_ff @(posedge iCLK) begin
                if (!iRST) begin
                    r_mainValid <= 1'b0;
                    r_skidValid <= 1'b0;
                end else if (r_skidValid) begin
                    if (w_outXfer) begin
                        r_mainData  <= r_skidData;
                        r_skidValid <= 1'b0;
                    end
                end else if (r_mainValid) begin
                    if (w_inXfer && w_outXfer) begin
                        r_mainData <= w_result;
                    end else if (w_inXfer) begin
                        r_skidData  <= w_result;
                        r_skidValid <= 1'b1;
                    end else if (w_outXfer) begin
                        r_mainValid <= 1'b0;
                    end
                end else if (w_inXfer) begin
                    r_mainData  <= w_result;
                    r_mainValid <= 1'b1;
                end
            end
        end else begin : g_single
            logic             r_valid;
            logic [WIDTH-1:0] r_data;

            assign oReady_AM_WS[i]           = w_laneEnable & ~r_valid;
            assign w_inXfer                  = iValid_AM_WS[i] & oReady_AM_WS[i];
            assign w_outXfer                 = r_valid & iReady_BM[i];
            assign oValid_BM[i]              = r_valid;
            assign oData_BM[i*WIDTH +: WIDTH] = r_data;
            assign w_laneOcc[i]              = r_valid;

            always_ff @(posedge iCLK) begin
                if (!iRST) begin
                    r_valid <= 1'b0;
                end else if (w_inXfer) begin
                    r_valid <= 1'b1;
                    r_data  <= w_result;
                end else if (w_outXfer) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bias_activate.sv
`default_nettype none
// Directed self-checking bench for bias_activate (SIZE_A=4, WIDTH=4, SIZE_B=2, burst lanes).
module tb_bias_activate;

    localparam int SIZE_A = 4;
    localparam int SIZE_B = 2;
    localparam int WIDTH  = 4;
    localparam int IW     = 6;

    logic                    iCLK = 1'b0;
    logic                    iRST;
    logic                    iValid_AM_B;
    logic                    oReady_AM_B;
    logic [SIZE_B*WIDTH-1:0] iData_AM_B;
    logic [SIZE_B-1:0]       iValid_AM_WS;
    logic [SIZE_B-1:0]       oReady_AM_WS;
    logic [SIZE_B*IW-1:0]    iData_AM_WS;
    logic [SIZE_B-1:0]       oValid_BM;
    logic [SIZE_B-1:0]       iReady_BM;
    logic [SIZE_B*WIDTH-1:0] oData_BM;

    int checks   = 0;
    int failures = 0;

    bias_activate #(
        .SIZE_A(SIZE_A),
        .SIZE_B(SIZE_B),
        .WIDTH (WIDTH),
        .BURST ("yes")
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iValid_AM_B (iValid_AM_B),
        .oReady_AM_B (oReady_AM_B),
        .iData_AM_B  (iData_AM_B),
        .iValid_AM_WS(iValid_AM_WS),
        .oReady_AM_WS(oReady_AM_WS),
        .iData_AM_WS (iData_AM_WS),
        .oValid_BM   (oValid_BM),
        .iReady_BM   (iReady_BM),
        .oData_BM    (oData_BM)
    );

    always #5 iCLK = ~iCLK;

    task automatic tick;
        @(posedge iCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        iRST = 1'b0; iValid_AM_B = 1'b0; iData_AM_B = '0;
        iValid_AM_WS = '0; iData_AM_WS = '0; iReady_BM = 2'b11;
        tick; tick;
        check("rst_valid",   {6'd0, oValid_BM},    8'h00);
        check("rst_readyWs", {6'd0, oReady_AM_WS}, 8'h00);
        check("rst_readyB",  {7'd0, oReady_AM_B},  8'h01);
        iRST = 1'b1;

        // Sums offered before any bias is loaded must be held off
        iValid_AM_WS = 2'b01; iData_AM_WS[5:0] = 6'd5;
        tick; tick;
        check("nobias_readyWs", {6'd0, oReady_AM_WS}, 8'h00);
        check("nobias_valid",   {6'd0, oValid_BM},    8'h00);
        check("nobias_readyB",  {7'd0, oReady_AM_B},  8'h01);
        iValid_AM_B = 1'b1; iData_AM_B = 8'h21;
        tick;
        check("load_readyWs", {6'd0, oReady_AM_WS}, 8'h03);
        check("load_readyB",  {7'd0, oReady_AM_B},  8'h00);
        check("load_valid",   {6'd0, oValid_BM},    8'h00);
        iValid_AM_B = 1'b0;
        iValid_AM_WS = 2'b11; iData_AM_WS[11:6] = 6'd20;
        tick;
        check("add_valid",    {6'd0, oValid_BM},     8'h03);
        check("add_lane0",    {4'd0, oData_BM[3:0]}, 8'h06);
        check("add_lane1sat", {4'd0, oData_BM[7:4]}, 8'h07);
        iValid_AM_WS = 2'b00;
        tick;
        check("add_drained", {6'd0, oValid_BM}, 8'h00);

        // Reload bias {lane1=-8, lane0=3} with empty lanes
        iValid_AM_B = 1'b1; iData_AM_B = 8'h83;
        tick;
        check("drain_readyB",  {7'd0, oReady_AM_B},  8'h01);
        check("drain_readyWs", {6'd0, oReady_AM_WS}, 8'h00);
        tick;
        iValid_AM_B = 1'b0;
        check("reload_readyWs", {6'd0, oReady_AM_WS}, 8'h03);
        iValid_AM_WS = 2'b11; iData_AM_WS = {6'b101100, 6'b110110};
        tick;
        check("neg_valid", {6'd0, oValid_BM}, 8'h03);
`ifdef BIAS_ACTIVATE_RELU_EN
        check("neg_lane0", {4'd0, oData_BM[3:0]}, 8'h00);
        check("neg_lane1", {4'd0, oData_BM[7:4]}, 8'h00);
`else
        check("neg_lane0", {4'd0, oData_BM[3:0]}, 8'h09);
        check("neg_lane1", {4'd0, oData_BM[7:4]}, 8'h08);
`endif
        iValid_AM_WS = 2'b00;
        tick;

        // Burst into stalled lane0 (bias 3); lane1 (bias -8) keeps flowing
        iReady_BM = 2'b10;
        iValid_AM_WS = 2'b11; iData_AM_WS = {6'd1, 6'd1};
        tick;
        check("burst_lane0_w0", {4'd0, oData_BM[3:0]}, 8'h04);
        check("burst_lane1",    {4'd0, oData_BM[7:4]}, 8'h09);
        check("burst_valid1",   {6'd0, oValid_BM},     8'h03);
        iValid_AM_WS = 2'b01; iData_AM_WS[5:0] = 6'd2;
        tick;
        check("burst_full_ready", {6'd0, oReady_AM_WS}, 8'h02);
        check("burst_lane1_done", {6'd0, oValid_BM},    8'h01);
        iData_AM_WS[5:0] = 6'd3;
        tick;
        check("burst_stall_ready", {6'd0, oReady_AM_WS}, 8'h02);
        check("burst_stall_head",  {4'd0, oData_BM[3:0]}, 8'h04);
        iReady_BM = 2'b11;
        tick;
        check("burst_rel_w1",    {4'd0, oData_BM[3:0]}, 8'h05);
        check("burst_rel_ready", {6'd0, oReady_AM_WS},  8'h03);
        tick;
        check("burst_rel_w2",    {4'd0, oData_BM[3:0]}, 8'h06);
        check("burst_rel_valid", {6'd0, oValid_BM},     8'h01);
        iValid_AM_WS = 2'b00;
        tick;
        check("burst_empty", {6'd0, oValid_BM}, 8'h00);

        // Bias reload while lane0 holds two old-bias words
        iReady_BM = 2'b10;
        iValid_AM_WS = 2'b01; iData_AM_WS[5:0] = 6'd0;
        tick;
        iData_AM_WS[5:0] = 6'd1;
        tick;
        iValid_AM_WS = 2'b00;
        iValid_AM_B = 1'b1; iData_AM_B = 8'h05;
        tick;
        check("hold_readyB",  {7'd0, oReady_AM_B},  8'h00);
        check("hold_readyWs", {6'd0, oReady_AM_WS}, 8'h00);
        tick;
        check("hold_readyB2", {7'd0, oReady_AM_B},  8'h00);
        iReady_BM = 2'b11;
        tick;
        check("hold_old_w1",  {4'd0, oData_BM[3:0]}, 8'h04);
        check("hold_readyB3", {7'd0, oReady_AM_B},   8'h00);
        tick;
        check("hold_readyB4", {7'd0, oReady_AM_B},   8'h01);
        check("hold_empty",   {6'd0, oValid_BM},     8'h00);
        iValid_AM_WS = 2'b01; iData_AM_WS[5:0] = 6'd1;
        tick;
        iValid_AM_B = 1'b0;
        check("newb_readyWs", {6'd0, oReady_AM_WS}, 8'h03);
        tick;
        check("newb_lane0", {4'd0, oData_BM[3:0]}, 8'h06);
        check("newb_valid", {6'd0, oValid_BM},     8'h01);
        iValid_AM_WS = 2'b00;
        tick;

        // Reset while both lanes are full
        iReady_BM = 2'b00;
        iValid_AM_WS = 2'b11; iData_AM_WS = {6'd0, 6'd0};
        tick;
        iData_AM_WS = {6'd1, 6'd1};
        tick;
        check("full_readyWs", {6'd0, oReady_AM_WS}, 8'h00);
        check("full_valid",   {6'd0, oValid_BM},    8'h03);
        iValid_AM_WS = 2'b00;
        iRST = 1'b0;
        tick;
        check("mrst_valid",   {6'd0, oValid_BM},    8'h00);
        check("mrst_readyWs", {6'd0, oReady_AM_WS}, 8'h00);
        check("mrst_readyB",  {7'd0, oReady_AM_B},  8'h01);
        check("mrst_bias",    dut.r_bias,           8'h00);
        iRST = 1'b1; iReady_BM = 2'b11;
        iValid_AM_B = 1'b1; iData_AM_B = 8'h11;
        tick;
        iValid_AM_B = 1'b0;
        check("post_valid",   {6'd0, oValid_BM},    8'h00);
        check("post_readyWs", {6'd0, oReady_AM_WS}, 8'h03);
        tick;
        check("post_valid2", {6'd0, oValid_BM}, 8'h00);
        iValid_AM_WS = 2'b10; iData_AM_WS[11:6] = 6'd2;
        tick;
        check("post_lane1_valid", {6'd0, oValid_BM},     8'h02);
        check("post_lane1_data",  {4'd0, oData_BM[7:4]}, 8'h03);
        iValid_AM_WS = 2'b00;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
